icache: RTL
===========

ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter LINE_CNT, default 64, meaning the number of direct-mapped lines; a power of 2, 16 bytes per line.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port rdy, input, 1, global ready; while low, all state and outputs hold.
REQ-005 SHALL have port ifu_req_valid, input, 1, instruction fetch request.
REQ-006 SHALL have port ifu_req_addr, input, 32, fetch PC; bits [1:0] are ignored.
REQ-007 SHALL have port ifu_req_ready, output, 1, combinational; high when state is IDLE.
REQ-008 SHALL have port ifu_clr, input, 1, which cancels any pending response (redirect).
REQ-009 SHALL have port ifu_rsp_valid, output, 1, a one-cycle pulse marking a returned instruction.
REQ-010 SHALL have port ifu_rsp_addr, output, 32, the PC of the returned instruction.
REQ-011 SHALL have port ifu_rsp_inst, output, 32, the returned instruction word.
REQ-012 SHALL have port mc_fc_valid, output, 1, registered line-fill request to the memory controller.
REQ-013 SHALL have port mc_fc_addr, output, 32, registered, line-aligned fill address with [3:0] = 0.
REQ-014 SHALL have port mc_fc_done, input, 1, a one-cycle pulse meaning the line is delivered.
REQ-015 SHALL have port mc_fc_line, input, 128, fill data; byte k is at bits [8k+7:8k].

Function
REQ-016 SHALL decompose the address as: offset [3:0]; word select [3:2]; index [3+log2(LINE_CNT):4]; tag = remaining upper bits.
REQ-017 SHALL store, per line, a valid bit, a tag and 128 data bits; valid bits are cleared only by rst.
REQ-018 SHALL implement two states: IDLE and MISS.
REQ-019 SHALL, in IDLE with ifu_req_valid and !ifu_clr and a hit, pulse ifu_rsp_valid in the next cycle.
- ifu_rsp_inst = stored line bits [32w+31:32w], where w = addr[3:2].
- ifu_rsp_addr = the request PC.
- State stays IDLE; back-to-back hits give one response per cycle.
REQ-020 SHALL, in IDLE on an accepted miss, transition as follows:
- Latch the PC.
- Set mc_fc_valid <= 1 and mc_fc_addr <= {addr[31:4],4'b0}.
- Enter MISS.
REQ-021 SHALL, in MISS, hold mc_fc_valid and mc_fc_addr stable until mc_fc_done is sampled high.
REQ-022 SHALL, on the edge that samples mc_fc_done in MISS:
- Write mc_fc_line, the tag and valid=1 into the indexed line.
- Clear mc_fc_valid.
- Return to IDLE.
- Pulse ifu_rsp_valid next cycle with the word selected from mc_fc_line, unless the miss was cancelled.
REQ-023 SHALL ensure mc_fc_valid is low in the cycle after mc_fc_done, so the controller cannot re-launch the same fill.
REQ-024 SHALL, on ifu_clr asserted in MISS, mark the miss cancelled.
- The fill still completes and is written to the array.
- No response is produced.
REQ-025 SHALL, on ifu_clr asserted in IDLE, not accept a request that cycle, and produce no ifu_rsp_valid in the next cycle.
REQ-026 SHALL ignore ifu_req_valid while in MISS (ifu_req_ready low); the IFU re-presents the request.
REQ-027 SHALL, while rdy is low, not advance state, not sample requests, and keep all outputs at their held values; ifu_rsp_valid is held low.
REQ-028 SHALL ignore mc_fc_done when in IDLE.

Reset
REQ-029 SHALL, on rst, set state to IDLE and clear all valid bits.
REQ-030 SHALL, on rst, drive the outputs to: mc_fc_valid=0, mc_fc_addr=0, ifu_rsp_valid=0, ifu_rsp_addr=0, ifu_rsp_inst=0.
REQ-031 SHALL let rst asserted during MISS abandon the fill with no array write and no response; rst has priority over rdy and over all other inputs.

Verification
REQ-032 Cold miss: request 0x00001004 after reset -> next cycle mc_fc_valid=1 and mc_fc_addr=0x00001000; on mc_fc_done with line 0x...DDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA -> next cycle ifu_rsp_valid=1, inst=0xBBBBBBBB, addr=0x00001004, and mc_fc_valid=0.
REQ-033 Hit stream: after REQ-032, requests 0x1000, 0x1008, 0x100C on consecutive cycles -> three consecutive responses AAAAAAAA, CCCCCCCC, DDDDDDDD with no mc_fc_valid.
REQ-034 Conflict eviction (LINE_CNT=64): fill 0x1000, then request 0x1400 (same index, different tag) -> miss with mc_fc_addr=0x1400; a subsequent request to 0x1000 misses again.
REQ-035 Cancel: ifu_clr pulsed during MISS for 0x2000 -> no ifu_rsp_valid after mc_fc_done; a following request to 0x2000 hits in one cycle.
REQ-036 Stall and reset: rdy=0 for 5 cycles during MISS -> mc_fc_valid and mc_fc_addr unchanged and no response; rst during MISS -> mc_fc_valid=0 next cycle, and 0x1000 misses afterwards.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped instruction cache, 16-byte lines, single outstanding line fill.
// Hits respond one cycle after the request; misses respond one cycle after mc_fc_done.
// rdy low freezes every state element; ifu_req_ready is low for the whole miss.
module icache #(
    parameter int LINE_CNT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    input  logic         ifu_req_valid,
    input  logic [31:0]  ifu_req_addr,
    output logic         ifu_req_ready,
    input  logic         ifu_clr,
    output logic         ifu_rsp_valid,
    output logic [31:0]  ifu_rsp_addr,
    output logic [31:0]  ifu_rsp_inst,
    output logic         mc_fc_valid,
    output logic [31:0]  mc_fc_addr,
    input  logic         mc_fc_done,
    input  logic [127:0] mc_fc_line
);
    localparam int IDX_W = $clog2(LINE_CNT);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic {IDLE, MISS} state_t;

    state_t             state, state_nxt;
    logic [LINE_CNT-1:0] line_valid;
    logic [TAG_W-1:0]   tag_mem  [LINE_CNT];
    logic [127:0]       data_mem [LINE_CNT];
    logic [31:0]        miss_pc;
    logic               cancelled;

    logic [IDX_W-1:0]   req_idx, miss_idx;
    logic [TAG_W-1:0]   req_tag, miss_tag;
    logic               hit;
    logic [31:0]        hit_word, fill_word;
    logic               take_hit, take_miss, take_fill;

    assign req_idx   = ifu_req_addr[4 +: IDX_W];
    assign req_tag   = ifu_req_addr[31 -: TAG_W];
    assign miss_idx  = miss_pc[4 +: IDX_W];
    assign miss_tag  = miss_pc[31 -: TAG_W];
    assign hit       = line_valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign hit_word  = data_mem[req_idx][{ifu_req_addr[3:2], 5'd0} +: 32];
    assign fill_word = mc_fc_line[{miss_pc[3:2], 5'd0} +: 32];

    assign ifu_req_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        take_hit  = 1'b0;
        take_miss = 1'b0;
        take_fill = 1'b0;
        if (rdy) begin
            unique case (state)
                IDLE: begin
                    if (ifu_req_valid && !ifu_clr) begin
                        if (hit) begin
                            take_hit = 1'b1;
                        end else begin
                            take_miss = 1'b1;
                            state_nxt = MISS;
                        end
                    end
                end
                MISS: begin
                    if (mc_fc_done) begin
                        take_fill = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_valid    <= '0;
            miss_pc       <= '0;
            cancelled     <= 1'b0;
            mc_fc_valid   <= 1'b0;
            mc_fc_addr    <= '0;
            ifu_rsp_valid <= 1'b0;
            ifu_rsp_addr  <= '0;
            ifu_rsp_inst  <= '0;
        end else if (!rdy) begin
            ifu_rsp_valid <= 1'b0;
        end else begin
            ifu_rsp_valid <= 1'b0;
            if (take_hit) begin
                ifu_rsp_valid <= 1'b1;
                ifu_rsp_addr  <= ifu_req_addr;
                ifu_rsp_inst  <= hit_word;
            end
            if (take_miss) begin
                miss_pc     <= ifu_req_addr;
                cancelled   <= 1'b0;
                mc_fc_valid <= 1'b1;
                mc_fc_addr  <= {ifu_req_addr[31:4], 4'b0};
            end
            if (state == MISS && ifu_clr) cancelled <= 1'b1;
            // A redirect coinciding with the fill edge also suppresses the response.
            if (take_fill) begin
                line_valid[miss_idx] <= 1'b1;
                mc_fc_valid          <= 1'b0;
                if (!(cancelled || ifu_clr)) begin
                    ifu_rsp_valid <= 1'b1;
                    ifu_rsp_addr  <= miss_pc;
                    ifu_rsp_inst  <= fill_word;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (take_fill && !rst) begin
            tag_mem[miss_idx]  <= miss_tag;
            data_mem[miss_idx] <= mc_fc_line;
        end
    end
endmodule
